agp32_mem_responder: RTL and testbench

Memory-side responder for the agp32 pipeline's memory command interface. Accepts the processor's `command`/`data_addr`/`data_wdata`/`data_wstrb`/`PC` requests, services instruction fetches, word reads and byte-strobed writes against an internal word-addressed RAM, and drives `ready`, `inst_rdata`, `data_rdata`, `error` and `mem_start_ready` back. Also acknowledges the processor's interrupt request handshake. A host-side load port fills the RAM before the processor is released.

---
 rtl/agp32_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_agp32_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agp32_mem_responder.sv
// Memory-side responder for the agp32 pipeline: host-loaded word RAM serving fetch/read/write
// commands with fixed latencies, plus an independent interrupt request/acknowledge handshake.
//   state  | meaning
//   S_LOAD | host fills RAM through the load port, processor commands ignored
//   S_IDLE | ready high, waiting for a non-zero command
//   S_BUSY | latched command counting down its latency, access happens at count 0
module agp32_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int FETCH_LAT = 1,
  parameter int DATA_LAT  = 2,
  parameter int INT_LAT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] PC,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic        interrupt_req,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        mem_start_ready,
  output logic [1:0]  error,
  output logic        interrupt_ack
);
  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] DEPTH     = 32'(MEM_WORDS);
  localparam logic [15:0] FETCH_CNT = 16'(FETCH_LAT - 1);
  localparam logic [15:0] DATA_CNT  = 16'(DATA_LAT - 1);
  localparam logic [15:0] INT_CNT   = 16'(INT_LAT - 1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_BUSY} state_e;

  state_e      state_q;
  logic [31:0] mem_q [MEM_WORDS];
  logic [2:0]  cmd_q;
  logic [29:0] pc_q, addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [15:0] cnt_q;
  logic        ready_q, start_q, ack_q;
  logic [31:0] inst_q, rdata_q;
  logic [1:0]  err_q;
  logic [15:0] int_cnt_q;

  logic [31:0] acc_word;
  logic        acc_ok;
  logic [AW-1:0] acc_idx;
  logic [31:0] acc_old, wr_word_d;
  logic        done, load_we, access_we;
  logic        unused_addr_lsbs;

  // Byte offset is irrelevant to a word RAM; only the word index is kept.
  assign unused_addr_lsbs = ^{PC[1:0], data_addr[1:0]};

  always_comb begin
    acc_word  = {2'b00, (cmd_q == 3'd1) ? pc_q : addr_q};
    acc_ok    = acc_word < DEPTH;
    acc_idx   = acc_word[AW-1:0];
    acc_old   = mem_q[acc_idx];
    wr_word_d = acc_old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) wr_word_d[8*b +: 8] = wdata_q[8*b +: 8];
    end
    done      = (state_q == S_BUSY) && (cnt_q == 16'd0);
    load_we   = (state_q == S_LOAD) && load_en && (load_addr < DEPTH);
    access_we = done && (cmd_q == 3'd3) && acc_ok;
  end

  // RAM survives reset; an edge with rst_n low never writes, which abandons an in-flight store.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (load_we)        mem_q[load_addr[AW-1:0]] <= load_data;
      else if (access_we) mem_q[acc_idx]           <= wr_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cmd_q   <= 3'd0;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      inst_q  <= 32'd63;
      rdata_q <= '0;
      err_q   <= 2'd0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (load_done) begin
            state_q <= S_IDLE;
            start_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (command != 3'd0) begin
            state_q <= S_BUSY;
            ready_q <= 1'b0;
            cmd_q   <= command;
            pc_q    <= PC[31:2];
            addr_q  <= data_addr[31:2];
            wdata_q <= data_wdata;
            wstrb_q <= data_wstrb;
            unique case (command)
              3'd1:        cnt_q <= FETCH_CNT;
              3'd2, 3'd3:  cnt_q <= DATA_CNT;
              default:     cnt_q <= 16'd0;
            endcase
          end
        end
        S_BUSY: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            unique case (cmd_q)
              3'd1: begin
                inst_q <= acc_ok ? acc_old : 32'd0;
                if (!acc_ok && err_q == 2'd0) err_q <= 2'd1;
              end
              3'd2: begin
                rdata_q <= acc_ok ? acc_old : 32'd0;
                if (!acc_ok && err_q == 2'd0) err_q <= 2'd1;
              end
              3'd3: begin
                if (!acc_ok && err_q == 2'd0) err_q <= 2'd1;
              end
              3'd4: ;
              default: begin
                if (err_q == 2'd0) err_q <= 2'd2;
              end
            endcase
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Interrupt handshake runs regardless of the command FSM.
  always_ff @(posedge clk) begin
    if (!rst_n || !interrupt_req) begin
      int_cnt_q <= '0;
      ack_q     <= 1'b0;
    end else if (!ack_q) begin
      if (int_cnt_q == INT_CNT) ack_q     <= 1'b1;
      else                      int_cnt_q <= int_cnt_q + 16'd1;
    end
  end

  assign ready           = ready_q;
  assign inst_rdata      = inst_q;
  assign data_rdata      = rdata_q;
  assign mem_start_ready = start_q;
  assign error           = err_q;
  assign interrupt_ack   = ack_q;
endmodule

// File: tb/tb_agp32_mem_responder.sv
// Self-checking bench for agp32_mem_responder: transaction-level reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_agp32_mem_responder;
  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;
  localparam int FETCH_LAT = 1;
  localparam int DATA_LAT  = 2;
  localparam int INT_LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  command = '0;
  logic [31:0] PC = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        interrupt_req = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0, load_data = '0;
  logic        load_done = 1'b0;
  logic        ready, mem_start_ready, interrupt_ack;
  logic [31:0] inst_rdata, data_rdata;
  logic [1:0]  error;

  agp32_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .FETCH_LAT(FETCH_LAT), .DATA_LAT(DATA_LAT), .INT_LAT(INT_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .PC(PC), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .interrupt_req(interrupt_req),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .ready(ready), .inst_rdata(inst_rdata), .data_rdata(data_rdata),
    .mem_start_ready(mem_start_ready), .error(error), .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_ram [MEM_WORDS];
  bit          m_run = 1'b0;
  bit          m_pend = 1'b0;
  int          m_done_cyc = 0;
  int          cyc = 0;
  int          irun = 0;
  logic [2:0]  p_cmd;
  logic [31:0] p_pc, p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  logic        e_ready = 1'b0, e_start = 1'b0, e_ack = 1'b0;
  logic [31:0] e_inst = 32'd63, e_rdata = 32'd0;
  logic [1:0]  e_err = 2'd0;

  function automatic int lat_of(input logic [2:0] c);
    if (c == 3'd1) return FETCH_LAT;
    if (c == 3'd2 || c == 3'd3) return DATA_LAT;
    return 1;
  endfunction

  task automatic model_complete();
    logic [31:0] idx;
    idx = (p_cmd == 3'd1) ? (p_pc >> 2) : (p_addr >> 2);
    if (p_cmd >= 3'd5) begin
      if (e_err == 2'd0) e_err = 2'd2;
    end else if (p_cmd != 3'd4) begin
      if (idx >= 32'(MEM_WORDS)) begin
        if (e_err == 2'd0) e_err = 2'd1;
        if (p_cmd == 3'd1) e_inst = 32'd0;
        if (p_cmd == 3'd2) e_rdata = 32'd0;
      end else if (p_cmd == 3'd1) begin
        e_inst = m_ram[idx[AW-1:0]];
      end else if (p_cmd == 3'd2) begin
        e_rdata = m_ram[idx[AW-1:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (p_wstrb[b]) m_ram[idx[AW-1:0]][8*b +: 8] = p_wdata[8*b +: 8];
      end
    end
    e_ready = 1'b1;
    m_pend  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) m_ram[i] = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_run = 1'b0; m_pend = 1'b0; irun = 0;
        e_ready = 1'b0; e_inst = 32'd63; e_rdata = 32'd0;
        e_start = 1'b0; e_err = 2'd0; e_ack = 1'b0;
      end else begin
        irun  = interrupt_req ? irun + 1 : 0;
        e_ack = (irun >= INT_LAT);
        if (!m_run) begin
          if (load_en && load_addr < 32'(MEM_WORDS)) m_ram[load_addr[AW-1:0]] = load_data;
          if (load_done) begin
            m_run = 1'b1; e_start = 1'b1; e_ready = 1'b1;
          end
        end else if (m_pend) begin
          if (cyc == m_done_cyc) model_complete();
        end else if (command != 3'd0) begin
          m_pend = 1'b1; e_ready = 1'b0;
          p_cmd = command; p_pc = PC; p_addr = data_addr;
          p_wdata = data_wdata; p_wstrb = data_wstrb;
          m_done_cyc = cyc + lat_of(command);
        end
      end
    end
  end

  // One compare process against the model on every cycle after reset is applied.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_ready", 32'(ready), 32'(e_ready));
        chk("m_inst_rdata", inst_rdata, e_inst);
        chk("m_data_rdata", data_rdata, e_rdata);
        chk("m_start_ready", 32'(mem_start_ready), 32'(e_start));
        chk("m_error", 32'(error), 32'(e_err));
        chk("m_interrupt_ack", 32'(interrupt_ack), 32'(e_ack));
      end
    end
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] c, input logic [31:0] pc_v, input logic [31:0] addr_v,
                         input logic [31:0] wd, input logic [3:0] ws, output int nlow);
    command = c; PC = pc_v; data_addr = addr_v; data_wdata = wd; data_wstrb = ws;
    @(negedge clk);
    command = 3'd0;
    nlow = 0;
    while (ready !== 1'b1 && nlow < 20) begin
      nlow++;
      @(negedge clk);
    end
  endtask

  task automatic restart();
    rst_n = 1'b1;
    @(negedge clk);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_inst", inst_rdata, 32'd63);
    chk("rst_rdata", data_rdata, 32'd0);
    chk("rst_start", 32'(mem_start_ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ack", 32'(interrupt_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load phase; the command below must be ignored while loading.
    command = 3'd2; data_addr = 32'h0;
    load_word(32'd0, 32'h12345678);
    command = 3'd0;
    load_word(32'd1, 32'h000000A5);
    load_word(32'd2, 32'h00000000);
    load_word(32'd3, 32'h11111111);
    load_word(32'd5, 32'hCAFEF00D);
    load_word(32'(MEM_WORDS), 32'h00000BAD);
    chk("load_ready_low", 32'(ready), 32'd0);
    load_en = 1'b1; load_addr = 32'd6; load_data = 32'h600D600D; load_done = 1'b1;
    @(negedge clk);
    load_en = 1'b0; load_done = 1'b0;
    chk("start_ready", 32'(mem_start_ready), 32'd1);
    chk("ready_after_load", 32'(ready), 32'd1);

    run_cmd(3'd1, 32'h4, 32'h0, 32'h0, 4'h0, n);
    chk("fetch_lat", 32'(n), 32'd1);
    chk("fetch_pc4", inst_rdata, 32'h000000A5);
    run_cmd(3'd1, 32'h3, 32'h0, 32'h0, 4'h0, n);
    chk("fetch_pc3_ovr_load", inst_rdata, 32'h12345678);

    run_cmd(3'd3, 32'h0, 32'h8, 32'hDEADBEEF, 4'b0101, n);
    chk("write_lat", 32'(n), 32'd2);
    run_cmd(3'd2, 32'h0, 32'h8, 32'h0, 4'h0, n);
    chk("read_lat", 32'(n), 32'd2);
    chk("read_after_write", data_rdata, 32'h00AD00EF);

    run_cmd(3'd3, 32'h0, 32'h14, 32'hFFFFFFFF, 4'b0000, n);
    chk("wstrb0_lat", 32'(n), 32'd2);
    run_cmd(3'd2, 32'h0, 32'h15, 32'h0, 4'h0, n);
    chk("wstrb0_unchanged", data_rdata, 32'hCAFEF00D);
    run_cmd(3'd2, 32'h0, 32'h18, 32'h0, 4'h0, n);
    chk("load_with_done", data_rdata, 32'h600D600D);

    // A write presented while busy must be dropped.
    command = 3'd2; data_addr = 32'h0;
    @(negedge clk);
    command = 3'd3; data_addr = 32'h4; data_wdata = 32'h0; data_wstrb = 4'hF;
    @(negedge clk);
    command = 3'd0;
    chk("busy_ready_low", 32'(ready), 32'd0);
    @(negedge clk);
    chk("busy_no_extra_lat", 32'(ready), 32'd1);
    chk("busy_read", data_rdata, 32'h12345678);
    run_cmd(3'd1, 32'h4, 32'h0, 32'h0, 4'h0, n);
    chk("busy_write_dropped", inst_rdata, 32'h000000A5);

    run_cmd(3'd4, 32'h0, 32'h0, 32'h0, 4'h0, n);
    chk("cmd4_lat", 32'(n), 32'd1);
    chk("cmd4_err", 32'(error), 32'd0);

    run_cmd(3'd2, 32'h0, 32'(4 * MEM_WORDS), 32'h0, 4'h0, n);
    chk("oor_rdata", data_rdata, 32'd0);
    chk("oor_err", 32'(error), 32'd1);
    run_cmd(3'd1, 32'hFFFFFFFC, 32'h0, 32'h0, 4'h0, n);
    chk("oor_fetch", inst_rdata, 32'd0);
    run_cmd(3'd7, 32'h0, 32'h0, 32'h0, 4'h0, n);
    chk("cmd7_lat", 32'(n), 32'd1);
    chk("err_sticky", 32'(error), 32'd1);

    // Interrupt handshake.
    interrupt_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (interrupt_ack !== 1'b1 && n < 10);
    chk("int_ack_delay", 32'(n), 32'd3);
    repeat (2) @(negedge clk);
    chk("int_ack_held", 32'(interrupt_ack), 32'd1);
    interrupt_req = 1'b0;
    @(negedge clk);
    chk("int_ack_drop", 32'(interrupt_ack), 32'd0);
    interrupt_req = 1'b1;
    repeat (2) @(negedge clk);
    interrupt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("int_short_pulse", 32'(interrupt_ack), 32'd0);
    end

    // Reset in the middle of a write: RAM[3] must keep its loaded value.
    command = 3'd3; data_addr = 32'hC; data_wdata = 32'hFFFFFFFF; data_wstrb = 4'hF;
    @(negedge clk);
    command = 3'd0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_inst", inst_rdata, 32'd63);
    chk("midrst_rdata", data_rdata, 32'd0);
    chk("midrst_start", 32'(mem_start_ready), 32'd0);
    chk("midrst_err", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    command = 3'd1; PC = 32'h0;
    @(negedge clk);
    command = 3'd0;
    chk("load_state_ignores_cmd", 32'(ready), 32'd0);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    chk("restart_ready", 32'(ready), 32'd1);
    run_cmd(3'd1, 32'hC, 32'h0, 32'h0, 4'h0, n);
    chk("midrst_ram_kept", inst_rdata, 32'h11111111);

    run_cmd(3'd6, 32'h0, 32'h0, 32'h0, 4'h0, n);
    chk("cmd6_err", 32'(error), 32'd2);
    run_cmd(3'd2, 32'h0, 32'h4, 32'h0, 4'h0, n);
    chk("service_after_err", data_rdata, 32'h000000A5);
    chk("err2_sticky", 32'(error), 32'd2);

    // Fresh reset clears the error but not the RAM.
    rst_n = 1'b0;
    @(negedge clk);
    restart();
    chk("rst_clears_err", 32'(error), 32'd0);
    run_cmd(3'd2, 32'h0, 32'h8, 32'h0, 4'h0, n);
    chk("ram_survives_rst", data_rdata, 32'h00AD00EF);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
